// File: rtl/replacer_pkg.sv
// Shared definitions for the run-length / sign token path feeding replacer_sign.
// Holds the default widths, the count-token layout and the encoder state set.
package replacer_pkg;

  localparam int LEN_W_DEF   = 7;
  localparam int MAX_RUN_DEF = 127;

  typedef struct packed {
    logic                 sign;
    logic [LEN_W_DEF-1:0] len;
  } cnt_tok_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/run_encoder_sign.sv
// Run-length encoder for the per-byte {eof, sign} tag stream: emits {sign, len} count
// tokens and one sign-FIFO entry per closed sign=1 region.
module run_encoder_sign
  import replacer_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int MAX_RUN = MAX_RUN_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  input  logic [1:0]     tag_in,
  input  logic           tag_empty,
  output logic           tag_rd,
  output logic [LEN_W:0] cnt_out,
  output logic           cnt_wr,
  input  logic           cnt_afull,
  output logic           sign_out,
  output logic           sign_wr,
  input  logic           sign_afull,
  output logic           busy
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_RUN);
  localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

  state_t           state, state_n;
  logic [LEN_W-1:0] run_len, run_len_n, len_inc;
  logic             run_sign, run_sign_n;
  logic [LEN_W:0]   pend_tok, pend_tok_n;
  logic             rd_pend;
  logic             region_open, region_open_n;
  logic             cnt_wr_q, sign_wr_q;
  logic             consume;
  logic             tag_eof, tag_sign;
  logic             emit, emit_sw, emit_so;
  logic [LEN_W:0]   emit_tok;

  assign tag_eof  = tag_in[1];
  assign tag_sign = tag_in[0];

  assign tag_rd  = clk_en & ~rst & ~tag_empty & ~cnt_afull & ~sign_afull & (state != FLUSH);
  assign cnt_wr  = cnt_wr_q & clk_en;
  assign sign_wr = sign_wr_q & clk_en;
  assign busy    = (state != IDLE);

  // A byte fetched just before FLUSH stays on the FIFO output (no new read), so it is
  // consumed on the following IDLE cycle instead.
  assign consume = clk_en & rd_pend & (state != FLUSH);

  always_comb begin
    state_n       = state;
    run_len_n     = run_len;
    run_sign_n    = run_sign;
    pend_tok_n    = pend_tok;
    region_open_n = region_open;
    len_inc       = run_len + 1'b1;
    emit          = 1'b0;
    emit_tok      = '0;
    emit_sw       = 1'b0;
    emit_so       = 1'b0;

    case (state)
      IDLE: begin
        if (consume) begin
          run_sign_n = tag_sign;
          run_len_n  = ONE_LEN;
          state_n    = RUN;
          if (tag_eof) begin
            emit          = 1'b1;
            emit_tok      = {tag_sign, ONE_LEN};
            emit_sw       = tag_sign | region_open;
            emit_so       = tag_sign;
            region_open_n = 1'b0;
            state_n       = IDLE;
          end else if (!tag_sign && region_open) begin
            // A sign region ended exactly on a MAX_RUN split; its close has no token of its own.
            emit_sw       = 1'b1;
            emit_so       = 1'b0;
            region_open_n = 1'b0;
          end
        end
      end

      RUN: begin
        if (consume) begin
          if (tag_sign != run_sign) begin
            emit          = 1'b1;
            emit_tok      = {run_sign, run_len};
            emit_sw       = run_sign;
            emit_so       = 1'b0;
            region_open_n = 1'b0;
            run_sign_n    = tag_sign;
            run_len_n     = ONE_LEN;
            if (tag_eof) begin
              pend_tok_n = {tag_sign, ONE_LEN};
              state_n    = FLUSH;
            end
          end else begin
            run_len_n = len_inc;
            if (len_inc == MAX_LEN || tag_eof) begin
              emit          = 1'b1;
              emit_tok      = {run_sign, len_inc};
              emit_sw       = run_sign & tag_eof;
              emit_so       = run_sign & tag_eof;
              region_open_n = run_sign & ~tag_eof;
              state_n       = IDLE;
            end
          end
        end
      end

      FLUSH: begin
        emit          = 1'b1;
        emit_tok      = pend_tok;
        emit_sw       = pend_tok[LEN_W];
        emit_so       = pend_tok[LEN_W];
        region_open_n = 1'b0;
        state_n       = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // Everything holds while clk_en is low; output strobes are registered one cycle after the decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      run_len     <= '0;
      run_sign    <= 1'b0;
      pend_tok    <= '0;
      rd_pend     <= 1'b0;
      region_open <= 1'b0;
      cnt_wr_q    <= 1'b0;
      sign_wr_q   <= 1'b0;
      cnt_out     <= '0;
      sign_out    <= 1'b0;
    end else if (clk_en) begin
      state       <= state_n;
      run_len     <= run_len_n;
      run_sign    <= run_sign_n;
      pend_tok    <= pend_tok_n;
      rd_pend     <= tag_rd | (rd_pend & ~consume);
      region_open <= region_open_n;
      cnt_wr_q    <= emit;
      sign_wr_q   <= emit_sw;
      if (emit)    cnt_out  <= emit_tok;
      if (emit_sw) sign_out <= emit_so;
    end
  end

endmodule
